biu_bus_ctrl: RTL and testbench

BIU_BUS_CTRL -- requirements
Module: biu_bus_ctrl

---
 rtl/biu_bus_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_biu_bus_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_bus_ctrl.sv
`timescale 1ns/1ps
// biu_bus_ctrl: bus interface unit that arbitrates execution-unit and prefetch
// requests onto one T1/T2/T3/TW/T4 bus cycle, with a wait-state timeout.
// Ports: clk, rst (async, active-low); eu_* request/ack channel with write
// data, read data and timeout flag; pf_* prefetch channel with flush;
// ready/bus_din from the bus; addr_bus, data_out, ale, rd, wr, m_io, busy out.
module biu_bus_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eu_req,
    input  logic              eu_we,
    input  logic              eu_io,
    input  logic [ADDR_W-1:0] eu_addr,
    input  logic [DATA_W-1:0] eu_wdata,
    output logic              eu_ack,
    output logic [DATA_W-1:0] eu_rdata,
    output logic              eu_err,
    input  logic              pf_req,
    input  logic [ADDR_W-1:0] pf_addr,
    input  logic              pf_flush,
    output logic              pf_ack,
    output logic [DATA_W-1:0] pf_rdata,
    input  logic              ready,
    input  logic [DATA_W-1:0] bus_din,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [DATA_W-1:0] data_out,
    output logic              ale,
    output logic              rd,
    output logic              wr,
    output logic              m_io,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4
    } state_e;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_e            state_q, state_d;
    logic              own_pf_q, own_pf_d;
    logic              we_q, we_d;
    logic              io_q, io_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wait_q, wait_d;
    logic [1:0]        loss_q, loss_d;
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] eu_rdata_q, eu_rdata_d;
    logic [DATA_W-1:0] pf_rdata_q, pf_rdata_d;
    logic              eu_ack_q, eu_ack_d;
    logic              pf_ack_q, pf_ack_d;
    logic              eu_err_q, eu_err_d;
    logic              ale_q, ale_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              m_io_q, m_io_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic              pf_pend;
    logic              pf_win;
    logic              go_t4;
    logic              tout;
    logic              strobe;
    logic [DATA_W-1:0] cap;

    always_comb begin
        state_d    = state_q;
        own_pf_d   = own_pf_q;
        we_d       = we_q;
        io_d       = io_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        loss_d     = loss_q;
        flush_d    = flush_q;
        eu_rdata_d = eu_rdata_q;
        pf_rdata_d = pf_rdata_q;
        eu_ack_d   = 1'b0;
        pf_ack_d   = 1'b0;
        eu_err_d   = 1'b0;
        pf_pend    = pf_req & ~pf_flush;
        pf_win     = 1'b0;
        go_t4      = 1'b0;
        tout       = 1'b0;
        cap        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (eu_req || pf_pend) begin
                    // PF only beats a contending EU after three straight losses
                    pf_win   = pf_pend && (!eu_req || loss_q == 2'd3);
                    state_d  = S_T1;
                    own_pf_d = pf_win;
                    wait_d   = '0;
                    flush_d  = 1'b0;
                    if (pf_win) begin
                        addr_d  = pf_addr;
                        we_d    = 1'b0;
                        io_d    = 1'b0;
                        wdata_d = '0;
                        loss_d  = '0;
                    end else begin
                        addr_d  = eu_addr;
                        we_d    = eu_we;
                        io_d    = eu_io;
                        wdata_d = eu_wdata;
                        if (pf_pend) begin
                            loss_d = loss_q + 2'd1;
                        end
                    end
                end
            end
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                if (ready) begin
                    go_t4 = 1'b1;
                end else begin
                    state_d = S_TW;
                    wait_d  = wait_q + 8'd1;
                end
            end
            S_TW: begin
                if (ready) begin
                    go_t4 = 1'b1;
                end else if (wait_q == WAIT_LIM) begin
                    go_t4 = 1'b1;
                    tout  = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_T4: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (go_t4) begin
            state_d = S_T4;
            cap     = tout ? '0 : bus_din;
            if (own_pf_q) begin
                // a flushed fetch still runs its bus cycle but reports nothing
                if (!(flush_q || pf_flush)) begin
                    pf_ack_d   = 1'b1;
                    pf_rdata_d = cap;
                end
            end else begin
                eu_ack_d = 1'b1;
                eu_err_d = tout;
                if (!we_q) begin
                    eu_rdata_d = cap;
                end
            end
        end

        if (state_q != S_IDLE && own_pf_q && pf_flush) begin
            flush_d = 1'b1;
        end

        strobe     = state_d inside {S_T2, S_T3, S_TW};
        ale_d      = state_d == S_T1;
        rd_d       = strobe & ~we_d;
        wr_d       = strobe & we_d;
        busy_d     = state_d != S_IDLE;
        data_out_d = (we_d && (strobe || state_d == S_T4)) ? wdata_d : '0;
        m_io_d     = (state_d == S_T1) ? ~io_d : m_io_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            own_pf_q   <= 1'b0;
            we_q       <= 1'b0;
            io_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_q     <= '0;
            loss_q     <= '0;
            flush_q    <= 1'b0;
            eu_rdata_q <= '0;
            pf_rdata_q <= '0;
            eu_ack_q   <= 1'b0;
            pf_ack_q   <= 1'b0;
            eu_err_q   <= 1'b0;
            ale_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            m_io_q     <= 1'b0;
            busy_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            own_pf_q   <= own_pf_d;
            we_q       <= we_d;
            io_q       <= io_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            loss_q     <= loss_d;
            flush_q    <= flush_d;
            eu_rdata_q <= eu_rdata_d;
            pf_rdata_q <= pf_rdata_d;
            eu_ack_q   <= eu_ack_d;
            pf_ack_q   <= pf_ack_d;
            eu_err_q   <= eu_err_d;
            ale_q      <= ale_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            m_io_q     <= m_io_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
        end
    end

    assign addr_bus = addr_q;
    assign data_out = data_out_q;
    assign ale      = ale_q;
    assign rd       = rd_q;
    assign wr       = wr_q;
    assign m_io     = m_io_q;
    assign busy     = busy_q;
    assign eu_ack   = eu_ack_q;
    assign eu_err   = eu_err_q;
    assign eu_rdata = eu_rdata_q;
    assign pf_ack   = pf_ack_q;
    assign pf_rdata = pf_rdata_q;

endmodule

// File: tb/tb_biu_bus_ctrl.sv
`timescale 1ns/1ps
// tb_biu_bus_ctrl: directed and randomized transfers through biu_bus_ctrl,
// with an ack scoreboard fed from a transaction-level model of the BIU.
module tb_biu_bus_ctrl;

    localparam int WMAX = 15;

    logic        clk;
    logic        rst;
    logic        eu_req, eu_we, eu_io;
    logic [19:0] eu_addr;
    logic [7:0]  eu_wdata;
    logic        eu_ack, eu_err;
    logic [7:0]  eu_rdata;
    logic        pf_req, pf_flush, pf_ack;
    logic [19:0] pf_addr;
    logic [7:0]  pf_rdata;
    logic        ready;
    logic [7:0]  bus_din;
    logic [19:0] addr_bus;
    logic [7:0]  data_out;
    logic        ale, rd, wr, m_io, busy;

    biu_bus_ctrl #(.ADDR_W(20), .DATA_W(8), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst),
        .eu_req(eu_req), .eu_we(eu_we), .eu_io(eu_io),
        .eu_addr(eu_addr), .eu_wdata(eu_wdata),
        .eu_ack(eu_ack), .eu_rdata(eu_rdata), .eu_err(eu_err),
        .pf_req(pf_req), .pf_addr(pf_addr), .pf_flush(pf_flush),
        .pf_ack(pf_ack), .pf_rdata(pf_rdata),
        .ready(ready), .bus_din(bus_din),
        .addr_bus(addr_bus), .data_out(data_out),
        .ale(ale), .rd(rd), .wr(wr), .m_io(m_io), .busy(busy)
    );

    typedef struct {
        bit         pf;
        logic [7:0] data;
        bit         err;
        int         cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mit;
    int          total;
    int          bad;
    int          cyc;
    int          loss;
    bit          eu_hold, pf_hold;
    logic [7:0]  m_eu_rd, m_pf_rd;
    logic [19:0] m_addr;
    logic        m_mio;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Ack monitor: pops the oldest expected completion whenever an ack shows.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && (eu_ack || pf_ack)) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL ack_unexpected: eu_ack=%b pf_ack=%b want none (cycle %0d)",
                             eu_ack, pf_ack, cyc);
                end else begin
                    mit = q.pop_front();
                    if ({eu_ack, pf_ack, (pf_ack ? pf_rdata : eu_rdata), eu_err, cyc}
                        !== {!mit.pf, mit.pf, mit.data, mit.err, mit.cyc}) begin
                        bad++;
                        $display("FAIL ack: got eu/pf=%b%b data=%h err=%b cyc=%0d want eu/pf=%b%b data=%h err=%b cyc=%0d",
                                 eu_ack, pf_ack, (pf_ack ? pf_rdata : eu_rdata), eu_err, cyc,
                                 !mit.pf, mit.pf, mit.data, mit.err, mit.cyc);
                    end
                end
            end
        end
    end

    // One arbitration slot, entered at the negedge of an idle cycle.
    task automatic round(input bit new_eu, input bit new_pf,
                         input bit e_we, input bit e_io,
                         input logic [19:0] e_addr, input logic [7:0] e_wd,
                         input logic [19:0] p_addr, input bit iflush,
                         input int w, input logic [7:0] d,
                         input bit fl2, input int abort_k);
        exp_t        it;
        bit          pe, pp, pwin, we, io, flushed;
        logic [19:0] a;
        logic [7:0]  wd, rdv;
        int          len;

        chk("idle", {busy, ale, rd, wr, eu_ack, pf_ack, eu_err, data_out,
                     m_io, addr_bus, eu_rdata, pf_rdata},
                    {7'b0, 8'h00, m_mio, m_addr, m_eu_rd, m_pf_rd});

        if (new_eu && !eu_hold) begin
            eu_req = 1'b1; eu_we = e_we; eu_io = e_io;
            eu_addr = e_addr; eu_wdata = e_wd; eu_hold = 1'b1;
        end
        if (new_pf && !pf_hold) begin
            pf_req = 1'b1; pf_addr = p_addr; pf_hold = 1'b1;
        end
        pf_flush = iflush;
        pe = eu_hold;
        pp = pf_hold && !iflush;
        if (!pe && !pp) begin
            @(negedge clk);
            pf_flush = 1'b0;
            return;
        end

        if (pe && pp) begin
            if (loss == 3) begin pwin = 1'b1; loss = 0; end
            else begin pwin = 1'b0; loss++; end
        end else if (pp) begin
            pwin = 1'b1; loss = 0;
        end else begin
            pwin = 1'b0;
        end

        if (pwin) begin
            a = pf_addr; we = 1'b0; io = 1'b0; wd = 8'h00;
        end else begin
            a = eu_addr; we = eu_we; io = eu_io; wd = eu_wdata;
        end
        flushed = fl2 && pwin;
        len = (w > WMAX) ? WMAX + 4 : w + 4;
        rdv = (w > WMAX) ? 8'h00 : d;

        if (abort_k == 0) begin
            it.pf  = pwin;
            it.err = (w > WMAX) && !pwin;
            it.cyc = cyc + len;
            if (pwin) begin
                if (!flushed) m_pf_rd = rdv;
                it.data = m_pf_rd;
            end else begin
                if (!we) m_eu_rd = rdv;
                it.data = m_eu_rd;
            end
            if (!flushed) q.push_back(it);
        end
        m_addr = a;
        m_mio  = pwin ? 1'b1 : !io;

        @(negedge clk);
        pf_flush = 1'b0;
        for (int k = 1; k <= len; k++) begin
            chk("bus", {busy, ale, rd, wr, m_io, addr_bus, data_out},
                       {1'b1, (k == 1), (!we && k >= 2 && k < len),
                        (we && k >= 2 && k < len), m_mio, a,
                        ((we && k >= 2) ? wd : 8'h00)});
            if (abort_k == k) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_async", {busy, wr, rd, ale, data_out, addr_bus}, 64'd0);
                eu_req = 1'b0; pf_req = 1'b0; ready = 1'b0;
                eu_hold = 1'b0; pf_hold = 1'b0;
                loss = 0; m_eu_rd = 8'h00; m_pf_rd = 8'h00;
                m_addr = 20'h0; m_mio = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
                return;
            end
            ready   = (w <= WMAX) && (k == w + 3);
            bus_din = (k == w + 3) ? d : 8'($urandom);
            if (k == 2) pf_flush = fl2;
            if (k == 3) pf_flush = 1'b0;
            if (k == len) begin
                ready = 1'b0;
                if (pwin) begin pf_req = 1'b0; pf_hold = 1'b0; end
                else begin eu_req = 1'b0; eu_hold = 1'b0; end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, w;
        total = 0; bad = 0; loss = 0;
        eu_hold = 1'b0; pf_hold = 1'b0;
        m_eu_rd = 8'h00; m_pf_rd = 8'h00; m_addr = 20'h0; m_mio = 1'b0;
        eu_req = 1'b0; eu_we = 1'b0; eu_io = 1'b0;
        eu_addr = 20'h0; eu_wdata = 8'h00;
        pf_req = 1'b0; pf_addr = 20'h0; pf_flush = 1'b0;
        ready = 1'b0; bus_din = 8'h00;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", {busy, ale, rd, wr, m_io, eu_ack, pf_ack, eu_err,
                      addr_bus, data_out, eu_rdata, pf_rdata}, 64'd0);
        rst = 1'b1;

        // EU memory read, zero waits
        round(1, 0, 0, 0, 20'h123E0, 8'h00, 20'h0, 0, 0, 8'h5A, 0, 0);
        // EU I/O write, two wait states
        round(1, 0, 1, 1, 20'h00060, 8'hAA, 20'h0, 0, 2, 8'h33, 0, 0);
        // EU read times out
        round(1, 0, 0, 0, 20'h12345, 8'h00, 20'h0, 0, 16, 8'h77, 0, 0);
        // EU read, ready on the last allowed wait state
        round(1, 0, 0, 1, 20'h0ABCD, 8'h00, 20'h0, 0, 15, 8'h96, 0, 0);
        // EU write times out
        round(1, 0, 1, 0, 20'h54321, 8'h11, 20'h0, 0, 16, 8'h22, 0, 0);
        // PF read, then a flushed PF read that must leave pf_rdata alone
        round(0, 1, 0, 0, 20'h0, 8'h00, 20'h123E0, 0, 1, 8'h3C, 0, 0);
        round(0, 1, 0, 0, 20'h0, 8'h00, 20'h123E1, 0, 0, 8'hC3, 1, 0);
        // reset in TW of a write, then a normal transfer
        round(1, 0, 1, 0, 20'h30000, 8'h5C, 20'h0, 0, 5, 8'h00, 0, 5);
        round(1, 0, 0, 0, 20'h30001, 8'h00, 20'h0, 0, 1, 8'hE7, 0, 0);
        // both requesters held: EU,EU,EU,PF,EU,...
        for (int n = 0; n < 8; n++) begin
            round(1, 1, 0, 0, 20'($urandom), 8'($urandom), 20'($urandom),
                  0, 0, 8'($urandom), 0, 0);
        end

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: w = 0;
                4, 5, 6:    w = $urandom_range(1, 3);
                7:          w = $urandom_range(14, 15);
                8:          w = 16;
                default:    w = $urandom_range(4, 8);
            endcase
            round($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom),
                  20'($urandom), $urandom_range(0, 7) == 0, w, 8'($urandom),
                  $urandom_range(0, 3) == 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("drain", q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
